testeio_pulse_pio: RTL

Parametrised Avalon-MM output PIO, the successor to the single-bit feedback/flag output ports in the `testeio` system. It drives a `WIDTH`-bit `out_port` from a memory-mapped data register. Software can write the whole register, or set and clear individual bits atomically. Selected bits can be put in auto-clearing pulse mode, where one shared down-counter times how long they stay high. Typical use: "done"/strobe feedback lines to the genetic-circuit datapath, with no software clear loop needed.

---
 rtl/testeio_pulse_pio_if.sv | 12 +
 rtl/testeio_pulse_pio.sv | 100 ++++++++++
 2 files changed

// File: rtl/testeio_pulse_pio_if.sv
// Avalon-MM slave bus bundle for testeio_pulse_pio: word address, select,
// active-low write strobe, 32-bit write data and combinational read data.
interface testeio_pulse_pio_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/testeio_pulse_pio.sv
// Avalon-MM output PIO with DATA/OUTSET/OUTCLEAR and optional auto-clearing
// pulse bits sharing one down-counter; pulse logic exists only with TESTEIO_PIO_PULSE_EN.
module testeio_pulse_pio #(
   parameter int unsigned          WIDTH         = 8,
   parameter int unsigned          CNT_W         = 16,
   parameter int unsigned          PULSE_DEFAULT = 16,
   parameter logic [WIDTH-1:0]     RESET_VALUE   = '0
) (
   input  logic                    clk,
   input  logic                    reset_n,
   testeio_pulse_pio_if.slave      bus,
   output logic [WIDTH-1:0]        out_port
);

   logic             wr;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] data_q, data_d, data_wr;
   logic             unused_wdata;

   assign wr           = bus.chipselect & ~bus.write_n;
   assign wdata        = bus.writedata[WIDTH-1:0];
   assign unused_wdata = ^bus.writedata;
   assign out_port     = data_q;

   // Software write effect on DATA, before any expiry clear is folded in
   always_comb begin
      data_wr = data_q;
      if (wr) begin
         case (bus.address)
            3'd0:    data_wr = wdata;
            3'd4:    data_wr = data_q | wdata;
            3'd5:    data_wr = data_q & ~wdata;
            default: data_wr = data_q;
         endcase
      end
   end

`ifdef TESTEIO_PIO_PULSE_EN
   logic [WIDTH-1:0] mode_q, mode_d;
   logic [CNT_W-1:0] plen_q, plen_d, cnt_q, cnt_d;
   logic             trig, expire;

   assign trig   = wr && (bus.address == 3'd0 || bus.address == 3'd4) && |(wdata & mode_q);
   assign expire = (cnt_q == CNT_W'(1));

   // A trigger outranks expiry: reload and skip the clear
   always_comb begin
      data_d = data_wr;
      mode_d = mode_q;
      plen_d = plen_q;
      cnt_d  = cnt_q;
      if (wr && bus.address == 3'd1) mode_d = wdata;
      if (wr && bus.address == 3'd2) plen_d = bus.writedata[CNT_W-1:0];
      if (trig) begin
         cnt_d = (plen_q == '0) ? CNT_W'(1) : plen_q;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (expire) data_d = data_wr & ~mode_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data_q <= RESET_VALUE;
         mode_q <= '0;
         plen_q <= CNT_W'(PULSE_DEFAULT);
         cnt_q  <= '0;
      end else begin
         data_q <= data_d;
         mode_q <= mode_d;
         plen_q <= plen_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         3'd0:    bus.readdata[WIDTH-1:0] = data_q;
         3'd1:    bus.readdata[WIDTH-1:0] = mode_q;
         3'd2:    bus.readdata[CNT_W-1:0] = plen_q;
         3'd3:    bus.readdata[0]         = (cnt_q != '0);
         default: bus.readdata            = '0;
      endcase
   end
`else
   assign data_d = data_wr;

   always_ff @(posedge clk) begin
      if (!reset_n) data_q <= RESET_VALUE;
      else          data_q <= data_d;
   end

   always_comb begin
      bus.readdata = '0;
      if (bus.address == 3'd0) bus.readdata[WIDTH-1:0] = data_q;
   end
`endif

endmodule
